// File: rtl/aes_pkg.sv
// Shared AES decrypt-path types and GF(2^8) helpers for the InvMixColumns stage.
// Column/state helpers use the byte map row r, column c = state[32*r+8*c +: 8].
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } inv_mix_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] b);
        logic [7:0] x8;
        x8 = gf_xtime(gf_xtime(gf_xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = gf_xtime(b);
        x8 = gf_xtime(gf_xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = gf_xtime(gf_xtime(b));
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Column words carry row 0 in the low byte.
    function automatic aes_word_t get_column(input aes_state_t s, input logic [1:0] c);
        aes_word_t w;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            w[8*r +: 8] = s[32*r + 8*int'(c) +: 8];
        end
        return w;
    endfunction

    function automatic aes_state_t put_column(input aes_state_t s, input logic [1:0] c,
                                              input aes_word_t w);
        aes_state_t t;
        t = s;
        for (int r = 0; r < 4; r++) begin
            t[32*r + 8*int'(c) +: 8] = w[8*r +: 8];
        end
        return t;
    endfunction

endpackage

// File: rtl/inv_mix_columns_if.sv
// Valid/ready handshake bundle around the InvMixColumns stage.
// master = upstream/downstream environment, slave = the stage itself.
interface inv_mix_columns_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_state;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/inv_mix_columns_column.sv
// Combinational InvMixColumns of one column: circulant [0E 0B 0D 09], row 0 in [7:0].
module inv_mix_column
    import aes_pkg::*;
(
    input  aes_word_t col_in,
    output aes_word_t col_out
);

    logic [7:0] b0, b1, b2, b3;

    assign b0 = col_in[7:0];
    assign b1 = col_in[15:8];
    assign b2 = col_in[23:16];
    assign b3 = col_in[31:24];

    assign col_out[7:0]   = gf_mul0e(b0) ^ gf_mul0b(b1) ^ gf_mul0d(b2) ^ gf_mul09(b3);
    assign col_out[15:8]  = gf_mul0e(b1) ^ gf_mul0b(b2) ^ gf_mul0d(b3) ^ gf_mul09(b0);
    assign col_out[23:16] = gf_mul0e(b2) ^ gf_mul0b(b3) ^ gf_mul0d(b0) ^ gf_mul09(b1);
    assign col_out[31:24] = gf_mul0e(b3) ^ gf_mul0b(b0) ^ gf_mul0d(b1) ^ gf_mul09(b2);

endmodule

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns stage: iterative one-column-per-cycle by default,
// fully parallel single-cycle build when INV_MIX_PARALLEL_EN is defined.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst,
    inv_mix_columns_if.slave bus
);

    inv_mix_state_e state;
    logic           in_ready_q;
    logic           out_valid_q;
    aes_state_t     out_state_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;

`ifdef INV_MIX_PARALLEL_EN

    aes_word_t  par_in  [4];
    aes_word_t  par_out [4];
    aes_state_t par_state;

    for (genvar g = 0; g < 4; g++) begin : g_col
        inv_mix_column u_col (
            .col_in  (par_in[g]),
            .col_out (par_out[g])
        );
    end

    always_comb begin
        par_state = '0;
        for (int c = 0; c < 4; c++) begin
            par_in[c] = get_column(bus.in_state, 2'(c));
        end
        for (int c = 0; c < 4; c++) begin
            par_state = put_column(par_state, 2'(c), par_out[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        out_state_q <= par_state;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`else

    aes_state_t work;
    logic [1:0] col_idx;
    aes_word_t  cur_col;
    aes_word_t  new_col;
    aes_state_t next_work;

    inv_mix_column u_col (
        .col_in  (cur_col),
        .col_out (new_col)
    );

    always_comb begin
        cur_col   = get_column(work, col_idx);
        next_work = put_column(work, col_idx, new_col);
    end

    // The final column is folded straight into out_state so the result appears on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            col_idx     <= 2'd0;
            work        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        work       <= bus.in_state;
                        col_idx    <= 2'd0;
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    work    <= next_work;
                    col_idx <= col_idx + 2'd1;
                    if (col_idx == 2'd3) begin
                        col_idx     <= 2'd0;
                        out_state_q <= next_work;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns against a generic GF(2^8) matrix model.
// Define INV_MIX_PARALLEL_EN for both bench and RTL to exercise the parallel build.
module tb_inv_mix_columns;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

`ifdef INV_MIX_PARALLEL_EN
    localparam int EXP_LAT   = 1;
    localparam int PRE_RESET = 0;
`else
    localparam int EXP_LAT   = 5;
    localparam int PRE_RESET = 2;
`endif

    localparam logic [31:0] INV_COEF = 32'h0E0B0D09;
    localparam logic [31:0] FWD_COEF = 32'h02030101;

    inv_mix_columns_if bus ();

    inv_mix_columns dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Applies the circulant matrix whose first row is coef (high byte first) to every column.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(coef[31-8*k -: 8], s[32*((r+k)%4) + 8*c +: 8]);
                end
                o[32*r + 8*c +: 8] = acc;
            end
        end
        return o;
    endfunction

    // Literal written column-major, column 0 row 0 as the leftmost byte.
    function automatic logic [127:0] mk_state(input logic [127:0] v);
        logic [127:0] s;
        s = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[32*r + 8*c +: 8] = v[127 - 8*(4*c + r) -: 8];
            end
        end
        return s;
    endfunction

    task automatic accept(input logic [127:0] s);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_state = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %b want 0", bus.in_ready);
        else passes++;
        checks++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid);
        else passes++;
        checks++;
        if (bus.out_state !== 128'h0) $display("[TB] FAIL reset_out_state got %h want 0", bus.out_state);
        else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL idle_in_ready got %b want 1", bus.in_ready);
        else passes++;
    endtask

    task automatic test_fixed(input string name, input logic [127:0] vin, input logic [127:0] vexp);
        int lat;
        logic [127:0] want;
        want = mk_state(vexp);
        accept(mk_state(vin));
        wait_valid(lat);
        checks++;
        if (lat !== EXP_LAT) $display("[TB] FAIL %s_latency got %0d want %0d", name, lat, EXP_LAT);
        else passes++;
        checks++;
        if (bus.out_state !== want) $display("[TB] FAIL %s_state got %h want %h", name, bus.out_state, want);
        else passes++;
        checks++;
        if (ref_mix(mk_state(vin), INV_COEF) !== want)
            $display("[TB] FAIL %s_model got %h want %h", name, ref_mix(mk_state(vin), INV_COEF), want);
        else passes++;
        release_out();
        checks++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL %s_drop got %b want 0", name, bus.out_valid);
        else passes++;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] a;
        logic [127:0] want;
        a    = {$urandom, $urandom, $urandom, $urandom};
        want = ref_mix(a, INV_COEF);
        accept(a);
        wait_valid(lat);
        bus.in_state = {$urandom, $urandom, $urandom, $urandom};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_state !== want || bus.in_ready !== 1'b0)
                $display("[TB] FAIL bp_hold cycle %0d got v=%b r=%b %h want v=1 r=0 %h",
                         i, bus.out_valid, bus.in_ready, bus.out_state, want);
            else passes++;
        end
        bus.in_valid = 1'b0;
        release_out();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("[TB] FAIL bp_release got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
        else passes++;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_ignored got %b want 0", bus.out_valid);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic seen;
        accept({$urandom, $urandom, $urandom, $urandom});
        repeat (PRE_RESET) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_state !== 128'h0 || bus.in_ready !== 1'b0)
            $display("[TB] FAIL mid_reset got v=%b r=%b %h want v=0 r=0 0",
                     bus.out_valid, bus.in_ready, bus.out_state);
        else passes++;
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("[TB] FAIL mid_reset_ghost got %b want 0", seen);
        else passes++;
    endtask

    task automatic test_round_trip();
        int lat;
        logic [127:0] s;
        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            accept(ref_mix(s, FWD_COEF));
            wait_valid(lat);
            checks++;
            if (bus.out_state !== s || bus.out_valid !== 1'b1)
                $display("[TB] FAIL round_trip %0d got v=%b %h want v=1 %h",
                         i, bus.out_valid, bus.out_state, s);
            else passes++;
            release_out();
        end
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fixed("fips_col", 128'h8E4DA1BC_00000000_00000000_00000000,
                               128'hDB135345_00000000_00000000_00000000);
        test_fixed("full_state", 128'h9FDC589D_01010101_C6C6C6C6_4D7EBDF8,
                                 128'hF20A225C_01010101_C6C6C6C6_2D26314C);
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
